// File: rtl/address_gen.sv
// -----------------------------------------------------------------------------
// address_gen
//
// Two-dimensional scan address generator that sits between the
// address-generation controller and a memory read port. While the controller
// holds preset_flag high the scan configuration is captured. Once preset_flag
// falls, the block emits one address per cycle: columns first, then rows.
// The last beat carries a one-cycle finish pulse. After that the block idles
// in WAIT until the controller pulses preset_flag again.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   en1          in   shared enable; low aborts any scan and forces WAIT
//   preset_flag  in   high = load configuration, low = run
//   base_addr    in   [ADDR_W] first address of the scan
//   col_stride   in   [ADDR_W] address increment between columns
//   line_stride  in   [ADDR_W] increment between row start addresses
//   num_cols_m1  in   [CNT_W]  columns per row minus one
//   num_rows_m1  in   [CNT_W]  rows minus one
//   addr         out  [ADDR_W] current scan address (meaningful with addr_valid)
//   addr_valid   out  addr holds a scan address this cycle
//   finish       out  one-cycle pulse on the final beat of a completed scan
// -----------------------------------------------------------------------------
module address_gen #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en1,
  input  logic              preset_flag,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] col_stride,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic [CNT_W-1:0]  num_cols_m1,
  input  logic [CNT_W-1:0]  num_rows_m1,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              finish
);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    PRESET = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t state_reg;

  // Captured configuration. The row start register doubles as the latched
  // base address: it is loaded with base_addr during PRESET and then advanced
  // by line_stride at each row boundary.
  logic [ADDR_W-1:0] col_stride_reg;
  logic [ADDR_W-1:0] line_stride_reg;
  logic [CNT_W-1:0]  cols_m1_reg;
  logic [CNT_W-1:0]  rows_m1_reg;
  logic [ADDR_W-1:0] row_start_reg;

  // Position of the beat currently presented on addr.
  logic [CNT_W-1:0]  col_cnt_reg;
  logic [CNT_W-1:0]  row_cnt_reg;

  // ---------------------------------------------------------------------------
  // Next-beat arithmetic for the RUN state (all modulo 2^ADDR_W)
  // ---------------------------------------------------------------------------
  logic              last_col;
  logic              last_row;
  logic              last_beat;
  logic [CNT_W-1:0]  col_cnt_next;
  logic [CNT_W-1:0]  row_cnt_next;
  logic [ADDR_W-1:0] row_start_next;
  logic [ADDR_W-1:0] addr_next;
  logic              next_is_last;
  logic              entry_is_last;

  always_comb begin
    last_col       = (col_cnt_reg == cols_m1_reg);
    last_row       = (row_cnt_reg == rows_m1_reg);
    last_beat      = last_col && last_row;

    row_start_next = row_start_reg;
    addr_next      = addr + col_stride_reg;
    col_cnt_next   = col_cnt_reg + CNT_W'(1);
    row_cnt_next   = row_cnt_reg;

    if (last_col) begin
      // Row boundary: jump relative to the row start, not the last column,
      // so col_stride never leaks into the row pitch.
      row_start_next = row_start_reg + line_stride_reg;
      addr_next      = row_start_reg + line_stride_reg;
      col_cnt_next   = '0;
      row_cnt_next   = row_cnt_reg + CNT_W'(1);
    end

    // finish is registered, so it must be decided one beat ahead.
    next_is_last  = (col_cnt_next == cols_m1_reg) && (row_cnt_next == rows_m1_reg);

    // The first beat is produced straight from the PRESET inputs; a 1x1 scan
    // therefore raises finish together with its only beat.
    entry_is_last = (num_cols_m1 == '0) && (num_rows_m1 == '0);
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= WAIT;
      col_stride_reg  <= '0;
      line_stride_reg <= '0;
      cols_m1_reg     <= '0;
      rows_m1_reg     <= '0;
      row_start_reg   <= '0;
      col_cnt_reg     <= '0;
      row_cnt_reg     <= '0;
      addr            <= '0;
      addr_valid      <= 1'b0;
      finish          <= 1'b0;
    end else begin
      case (state_reg)
        WAIT: begin
          // Also the landing state after a completed scan. The controller's
          // preset_flag lags finish, so a low flag here must never restart.
          addr_valid <= 1'b0;
          finish     <= 1'b0;
          if (preset_flag && en1) begin
            state_reg <= PRESET;
          end
        end

        PRESET: begin
          // Configuration is captured on every PRESET cycle, including the
          // one where preset_flag is seen low, so the last value wins.
          col_stride_reg  <= col_stride;
          line_stride_reg <= line_stride;
          cols_m1_reg     <= num_cols_m1;
          rows_m1_reg     <= num_rows_m1;
          row_start_reg   <= base_addr;
          col_cnt_reg     <= '0;
          row_cnt_reg     <= '0;
          addr_valid      <= 1'b0;
          finish          <= 1'b0;

          if (!en1) begin
            state_reg <= WAIT;
          end else if (!preset_flag) begin
            // First beat goes out on this same edge.
            state_reg  <= RUN;
            addr       <= base_addr;
            addr_valid <= 1'b1;
            finish     <= entry_is_last;
          end
        end

        RUN: begin
          if (!en1) begin
            // Abort: drop the beat immediately, no finish for this scan.
            state_reg  <= WAIT;
            addr_valid <= 1'b0;
            finish     <= 1'b0;
          end else if (preset_flag) begin
            // Restart: reload configuration before running again.
            state_reg  <= PRESET;
            addr_valid <= 1'b0;
            finish     <= 1'b0;
          end else if (last_beat) begin
            // The final beat (with finish) was presented this cycle.
            state_reg  <= WAIT;
            addr_valid <= 1'b0;
            finish     <= 1'b0;
          end else begin
            addr          <= addr_next;
            row_start_reg <= row_start_next;
            col_cnt_reg   <= col_cnt_next;
            row_cnt_reg   <= row_cnt_next;
            addr_valid    <= 1'b1;
            finish        <= next_is_last;
          end
        end

        default: begin
          state_reg  <= WAIT;
          addr_valid <= 1'b0;
          finish     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_address_gen.sv
// -----------------------------------------------------------------------------
// tb_address_gen
//
// Bench for address_gen. A behavioural model predicts addr/addr_valid/finish
// from the scan rules using a beat index (address = base + row*line_stride +
// col*col_stride). A compare process checks the DUT against the model on every
// falling edge. Directed scenarios also compare the captured beat list with
// hand-computed literal address sequences.
// -----------------------------------------------------------------------------
module tb_address_gen;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en1;
  logic              preset_flag;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] col_stride;
  logic [ADDR_W-1:0] line_stride;
  logic [CNT_W-1:0]  num_cols_m1;
  logic [CNT_W-1:0]  num_rows_m1;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              finish;

  always #5 clk = ~clk;

  address_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en1        (en1),
    .preset_flag(preset_flag),
    .base_addr  (base_addr),
    .col_stride (col_stride),
    .line_stride(line_stride),
    .num_cols_m1(num_cols_m1),
    .num_rows_m1(num_rows_m1),
    .addr       (addr),
    .addr_valid (addr_valid),
    .finish     (finish)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  // Captured beats as {finish, addr}.
  logic [16:0] cap_q[$];
  logic [16:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_beats(input string name, input logic [16:0] want[$]);
    chk({name, "_count"}, cap_q.size(), want.size());
    for (int i = 0; i < want.size() && i < cap_q.size(); i++) begin
      chk($sformatf("%s_beat%0d", name, i), {15'd0, cap_q[i]}, {15'd0, want[i]});
    end
    $display("scan %s: %0d beats captured", name, cap_q.size());
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: mode 0 = idle, 1 = loading, 2 = scanning
  // ---------------------------------------------------------------------------
  int          m_mode;
  int          m_idx;
  int          m_total;
  int          m_ncols;
  logic [15:0] m_base;
  logic [15:0] m_cs;
  logic [15:0] m_ls;
  logic        e_valid;
  logic        e_fin;
  logic [15:0] e_addr;

  function automatic logic [15:0] beat_addr(input int i);
    int a;
    a = int'(m_base) + (i / m_ncols) * int'(m_ls) + (i % m_ncols) * int'(m_cs);
    return a[15:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode  = 0;
      e_valid = 1'b0;
      e_fin   = 1'b0;
      e_addr  = 16'h0;
    end else begin
      case (m_mode)
        0: begin
          e_valid = 1'b0;
          e_fin   = 1'b0;
          if (preset_flag && en1) m_mode = 1;
        end
        1: begin
          m_base  = base_addr;
          m_cs    = col_stride;
          m_ls    = line_stride;
          m_ncols = int'(num_cols_m1) + 1;
          m_total = m_ncols * (int'(num_rows_m1) + 1);
          e_valid = 1'b0;
          e_fin   = 1'b0;
          if (!en1) begin
            m_mode = 0;
          end else if (!preset_flag) begin
            m_mode  = 2;
            m_idx   = 0;
            e_valid = 1'b1;
            e_addr  = beat_addr(0);
            e_fin   = (m_total == 1);
          end
        end
        default: begin
          if (!en1) begin
            m_mode = 0; e_valid = 1'b0; e_fin = 1'b0;
          end else if (preset_flag) begin
            m_mode = 1; e_valid = 1'b0; e_fin = 1'b0;
          end else if (m_idx == m_total - 1) begin
            m_mode = 0; e_valid = 1'b0; e_fin = 1'b0;
          end else begin
            m_idx++;
            e_valid = 1'b1;
            e_addr  = beat_addr(m_idx);
            e_fin   = (m_idx == m_total - 1);
          end
        end
      endcase
    end
  end

  // Compare and capture, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_valid", {31'd0, addr_valid}, {31'd0, e_valid});
      chk("model_finish", {31'd0, finish}, {31'd0, e_fin});
      if (e_valid) chk("model_addr", {16'd0, addr}, {16'd0, e_addr});
      if (addr_valid) cap_q.push_back({finish, addr});
    end
  end

  // Load a configuration with a one-cycle preset pulse; returns on the
  // falling edge where beat 0 is visible.
  task automatic launch(input logic [15:0] b, input logic [15:0] cs, input logic [15:0] ls,
                        input logic [7:0] nc, input logic [7:0] nr);
    @(negedge clk);
    base_addr   = b;
    col_stride  = cs;
    line_stride = ls;
    num_cols_m1 = nc;
    num_rows_m1 = nr;
    en1         = 1'b1;
    preset_flag = 1'b1;
    @(negedge clk);
    preset_flag = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en1 = 1'b0; preset_flag = 1'b0;
    base_addr = '0; col_stride = '0; line_stride = '0;
    num_cols_m1 = '0; num_rows_m1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_addr", {16'd0, addr}, 32'h0);
    chk("reset_valid", {31'd0, addr_valid}, 32'h0);
    chk("reset_finish", {31'd0, finish}, 32'h0);
    rst = 1'b0;
    cmp_on = 1'b1;

    // Basic scan, followed by idle cycles with preset_flag low.
    cap_q.delete();
    launch(16'h0100, 16'h0001, 16'h0010, 8'd2, 8'd1);
    repeat (12) @(negedge clk);
    exp_q = '{17'h00100, 17'h00101, 17'h00102, 17'h00110, 17'h00111, 17'h10112};
    check_beats("basic", exp_q);

    // Single beat.
    cap_q.delete();
    launch(16'h0040, 16'h0003, 16'h0100, 8'd0, 8'd0);
    repeat (4) @(negedge clk);
    exp_q = '{17'h10040};
    check_beats("single", exp_q);

    // Wrap-around.
    cap_q.delete();
    launch(16'hFFFE, 16'h0001, 16'h0000, 8'd3, 8'd0);
    repeat (8) @(negedge clk);
    exp_q = '{17'h0FFFE, 17'h0FFFF, 17'h00000, 17'h10001};
    check_beats("wrap", exp_q);

    // Abort on the 3rd beat; WAIT must hold until en1 and preset_flag are both high.
    cap_q.delete();
    launch(16'h0100, 16'h0001, 16'h0010, 8'd2, 8'd1);
    repeat (2) @(negedge clk);
    en1 = 1'b0;
    @(negedge clk);
    chk("abort_valid", {31'd0, addr_valid}, 32'h0);
    preset_flag = 1'b1;
    repeat (3) @(negedge clk);
    preset_flag = 1'b0;
    en1 = 1'b1;
    repeat (3) @(negedge clk);
    exp_q = '{17'h00100, 17'h00101, 17'h00102};
    check_beats("abort", exp_q);

    // Restart mid-scan with a new base address.
    cap_q.delete();
    launch(16'h0100, 16'h0001, 16'h0010, 8'd2, 8'd1);
    @(negedge clk);
    preset_flag = 1'b1;
    base_addr   = 16'h0200;
    @(negedge clk);
    chk("restart_valid", {31'd0, addr_valid}, 32'h0);
    preset_flag = 1'b0;
    repeat (10) @(negedge clk);
    exp_q = '{17'h00100, 17'h00101, 17'h00200, 17'h00201, 17'h00202,
              17'h00210, 17'h00211, 17'h10212};
    check_beats("restart", exp_q);

    // Reset during beat 4.
    cap_q.delete();
    launch(16'h0100, 16'h0001, 16'h0010, 8'd2, 8'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_addr", {16'd0, addr}, 32'h0);
    chk("midrst_valid", {31'd0, addr_valid}, 32'h0);
    chk("midrst_finish", {31'd0, finish}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    exp_q = '{17'h00100, 17'h00101, 17'h00102, 17'h00110, 17'h00111};
    check_beats("midrst", exp_q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
